// File: rtl/dram_cmd_timer_if.sv
// rtl/dram_cmd_timer_if.sv - command/ack handshake and device strobe bundle for dram_cmd_timer
interface dram_cmd_timer_if;
  logic       cmd_req;
  logic [1:0] cmd;
  logic       count_en;
  logic       cmd_ack;
  logic       refresh_flag;
  logic       act_stb;
  logic       rd_stb;
  logic       ref_stb;
  logic       pre_stb;
  logic       busy;
  logic       seq_err;

  modport master (
    output cmd_req, cmd, count_en,
    input  cmd_ack, refresh_flag, act_stb, rd_stb, ref_stb, pre_stb, busy, seq_err
  );

  modport slave (
    input  cmd_req, cmd, count_en,
    output cmd_ack, refresh_flag, act_stb, rd_stb, ref_stb, pre_stb, busy, seq_err
  );
endinterface

// File: rtl/dram_cmd_timer.sv
// rtl/dram_cmd_timer.sv - DRAM command executor with per-command timing and refresh interval counter
// Optional open-row sequence checking is built when DRAM_CMD_TIMER_SEQ_CHECK_EN is defined.
module dram_cmd_timer #(
  parameter int unsigned T_RCD  = 3,
  parameter int unsigned T_CL   = 2,
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_RFC  = 8,
  parameter int unsigned T_REFI = 1000,
  parameter int unsigned TMR_W  = 10
) (
  input  logic clk,
  input  logic rst_b,
  dram_cmd_timer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_REF = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;
  localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

  state_e           state_q;
  logic [1:0]       cmd_q;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] hold_d;
  logic             ack_q, busy_q, act_q, rd_q, ref_q, pre_q;
  logic [TMR_W-1:0] refi_q, refi_d;
  logic             flag_q, flag_d;
  logic             ack_exit;

  // Cycles still to spend after the strobe cycle before ack is raised.
  always_comb begin
    hold_d = '0;
    case (cmd_q)
      CMD_ACT: hold_d = TMR_W'(T_RCD - 1);
      CMD_RD:  hold_d = TMR_W'(T_CL - 1);
      CMD_REF: hold_d = TMR_W'(T_RFC - 1);
      default: hold_d = TMR_W'(T_RP - 1);
    endcase
  end

  assign ack_exit = (state_q == S_ACK) && !bus.cmd_req;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_ACT;
      timer_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      act_q   <= 1'b0;
      rd_q    <= 1'b0;
      ref_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      act_q <= 1'b0;
      rd_q  <= 1'b0;
      ref_q <= 1'b0;
      pre_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_req) begin
            cmd_q   <= bus.cmd;
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            act_q   <= (bus.cmd == CMD_ACT);
            rd_q    <= (bus.cmd == CMD_RD);
            ref_q   <= (bus.cmd == CMD_REF);
            pre_q   <= (bus.cmd == CMD_PRE);
          end
        end
        S_ISSUE: begin
          if (hold_d == '0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end else begin
            timer_q <= hold_d - ONE;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (timer_q == '0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end else begin
            timer_q <= timer_q - ONE;
          end
        end
        S_ACK: begin
          if (!bus.cmd_req) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A completing REFRESH restarts the interval even if the flag is set on the same edge.
  always_comb begin
    refi_d = refi_q;
    flag_d = flag_q;
    if (ack_exit && (cmd_q == CMD_REF)) begin
      refi_d = '0;
      flag_d = 1'b0;
    end else if (bus.count_en && !flag_q) begin
      if (refi_q == TMR_W'(T_REFI - 2)) begin
        refi_d = TMR_W'(T_REFI - 1);
        flag_d = 1'b1;
      end else begin
        refi_d = refi_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      refi_q <= '0;
      flag_q <= 1'b0;
    end else begin
      refi_q <= refi_d;
      flag_q <= flag_d;
    end
  end

`ifdef DRAM_CMD_TIMER_SEQ_CHECK_EN
  logic row_open_q, seq_err_q;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      row_open_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.cmd_req &&
          (((bus.cmd == CMD_REF) && row_open_q) ||
           ((bus.cmd == CMD_RD)  && !row_open_q) ||
           ((bus.cmd == CMD_ACT) && row_open_q))) begin
        seq_err_q <= 1'b1;
      end
      if (ack_exit) begin
        if (cmd_q == CMD_ACT) begin
          row_open_q <= 1'b1;
        end else if ((cmd_q == CMD_PRE) || (cmd_q == CMD_REF)) begin
          row_open_q <= 1'b0;
        end
      end
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.cmd_ack      = ack_q;
  assign bus.busy         = busy_q;
  assign bus.act_stb      = act_q;
  assign bus.rd_stb       = rd_q;
  assign bus.ref_stb      = ref_q;
  assign bus.pre_stb      = pre_q;
  assign bus.refresh_flag = flag_q;

endmodule

// File: tb/tb_dram_cmd_timer.sv
// tb/tb_dram_cmd_timer.sv - self-checking bench for dram_cmd_timer
// Vector table, hand-written corner sequences and a randomized run against a transaction-level model.
module tb_dram_cmd_timer;

  localparam int T_RCD  = 3;
  localparam int T_CL   = 2;
  localparam int T_RP   = 3;
  localparam int T_RFC  = 8;
  localparam int T_REFI = 16;

`ifdef DRAM_CMD_TIMER_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  logic clk;
  logic rst_b;
  dram_cmd_timer_if bus();

  dram_cmd_timer #(
    .T_RCD(T_RCD), .T_CL(T_CL), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .TMR_W(10)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] cmd;
    int         hold;
    logic [3:0] stb;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [3:0] stbs();
    return {bus.pre_stb, bus.ref_stb, bus.rd_stb, bus.act_stb};
  endfunction

  function automatic int tdur(input logic [1:0] c);
    case (c)
      2'b00:   return T_RCD;
      2'b01:   return T_CL;
      2'b10:   return T_RFC;
      default: return T_RP;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b        = 1'b1;
    bus.cmd_req  = 1'b0;
    bus.cmd      = 2'b00;
    bus.count_en = 1'b0;
    repeat (2) tick();
    rst_b = 1'b0;
  endtask

  initial begin
    int n, acks, nstb, first;
    int m_busy, m_k, en_cnt;
    logic [1:0] m_cmd;
    logic ref_exit;
    logic [6:0] exp_v;

    vecs[0] = '{2'b00, 1, 4'b0001, 1 + T_RCD};
    vecs[1] = '{2'b01, 1, 4'b0010, 1 + T_CL};
    vecs[2] = '{2'b10, 2, 4'b0100, 1 + T_RFC};
    vecs[3] = '{2'b11, 1, 4'b1000, 1 + T_RP};
    vecs[4] = '{2'b00, 5, 4'b0001, 1 + T_RCD};
    vecs[5] = '{2'b01, 3, 4'b0010, 1 + T_CL};

    // Reset state
    do_reset();
    chk("reset_outputs", {bus.cmd_ack, bus.busy, stbs(), bus.refresh_flag}, 7'd0);
    chk("reset_seq_err", bus.seq_err, 1'b0);

    // Table-driven single commands
    foreach (vecs[i]) begin
      do_reset();
      bus.cmd     = vecs[i].cmd;
      bus.cmd_req = 1'b1;
      tick();
      chk($sformatf("v%0d_strobe", i), stbs(), vecs[i].stb);
      chk($sformatf("v%0d_busy_issue", i), bus.busy, 1'b1);
      nstb = 1;
      n = 1;
      while (!bus.cmd_ack && n < 40) begin
        tick();
        n++;
        if (stbs() != 4'b0) nstb++;
      end
      chk($sformatf("v%0d_ack_latency", i), n, vecs[i].lat);
      for (int h = 1; h < vecs[i].hold; h++) begin
        tick();
        if (stbs() != 4'b0) nstb++;
        chk($sformatf("v%0d_ack_held", i), bus.cmd_ack, 1'b1);
      end
      bus.cmd_req = 1'b0;
      tick();
      chk($sformatf("v%0d_ack_drop", i), {bus.cmd_ack, bus.busy}, 2'b00);
      chk($sformatf("v%0d_strobe_count", i), nstb, 1);
    end

    // Refresh interval counting, pause, REFRESH command and restart
    do_reset();
    bus.count_en = 1'b1;
    repeat (T_REFI - 2) tick();
    chk("refi_not_yet", bus.refresh_flag, 1'b0);
    bus.count_en = 1'b0;
    repeat (5) tick();
    chk("refi_paused", bus.refresh_flag, 1'b0);
    bus.count_en = 1'b1;
    tick();
    chk("refi_due", bus.refresh_flag, 1'b1);
    repeat (3) tick();
    chk("refi_sticky", bus.refresh_flag, 1'b1);
    bus.cmd     = 2'b10;
    bus.cmd_req = 1'b1;
    tick();
    chk("ref_strobe", stbs(), 4'b0100);
    n = 1;
    while (!bus.cmd_ack && n < 40) begin
      tick();
      n++;
    end
    chk("ref_ack_latency", n, 1 + T_RFC);
    chk("ref_flag_during_cmd", bus.refresh_flag, 1'b1);
    bus.cmd_req = 1'b0;
    tick();
    chk("ref_flag_cleared", bus.refresh_flag, 1'b0);
    repeat (T_REFI - 2) tick();
    chk("refi_restart_not_yet", bus.refresh_flag, 1'b0);
    tick();
    chk("refi_restart_due", bus.refresh_flag, 1'b1);

    // Async reset during WAIT of ACTIVATE
    do_reset();
    bus.cmd     = 2'b00;
    bus.cmd_req = 1'b1;
    tick();
    tick();
    #2 rst_b = 1'b1;
    #1;
    chk("rst_mid_busy_ack", {bus.busy, bus.cmd_ack}, 2'b00);
    bus.cmd_req = 1'b0;
    tick();
    rst_b = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.cmd_ack || bus.busy) acks++;
    end
    chk("rst_mid_no_completion", acks, 0);

    // cmd_req dropped before ACK: single-cycle ack at normal latency
    do_reset();
    bus.cmd     = 2'b00;
    bus.cmd_req = 1'b1;
    tick();
    bus.cmd_req = 1'b0;
    n = 1;
    acks = 0;
    first = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n++;
      if (bus.cmd_ack) begin
        acks++;
        if (first == 0) first = n;
      end
    end
    chk("early_drop_ack_cycle", first, 1 + T_RCD);
    chk("early_drop_ack_width", acks, 1);
    chk("early_drop_idle", bus.busy, 1'b0);

    // READ with no open row
    do_reset();
    bus.cmd     = 2'b01;
    bus.cmd_req = 1'b1;
    tick();
    chk("seq_err_read_first", bus.seq_err, SEQ_EXP);
    repeat (4) tick();
    bus.cmd_req = 1'b0;
    tick();
    chk("seq_err_sticky", bus.seq_err, SEQ_EXP);

    // Randomized run against a transaction-level model
    do_reset();
    m_busy = 0;
    m_k    = 0;
    m_cmd  = 2'b00;
    en_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_v[6] = (m_busy != 0);
      exp_v[5] = (m_busy != 0) && (m_k >= 1 + tdur(m_cmd));
      exp_v[4:1] = ((m_busy != 0) && (m_k == 1)) ? (4'b0001 << m_cmd) : 4'b0000;
      exp_v[0] = (en_cnt == T_REFI - 1);
      chk("random_cycle", {bus.busy, bus.cmd_ack, stbs(), bus.refresh_flag}, exp_v);

      if (!bus.cmd_req) begin
        if ((m_busy == 0) && ($urandom_range(0, 2) == 0)) begin
          bus.cmd     = 2'($urandom_range(0, 3));
          bus.cmd_req = 1'b1;
        end
      end else if ((m_busy != 0) && (m_k >= 1 + tdur(m_cmd))) begin
        if ($urandom_range(0, 2) == 0) bus.cmd_req = 1'b0;
      end else if ((m_busy != 0) && ($urandom_range(0, 15) == 0)) begin
        bus.cmd_req = 1'b0;
      end
      bus.count_en = ($urandom_range(0, 3) != 0);

      ref_exit = 1'b0;
      if (m_busy != 0) begin
        if ((m_k >= 1 + tdur(m_cmd)) && !bus.cmd_req) begin
          m_busy   = 0;
          ref_exit = (m_cmd == 2'b10);
        end else begin
          m_k++;
        end
      end else if (bus.cmd_req) begin
        m_busy = 1;
        m_k    = 1;
        m_cmd  = bus.cmd;
      end
      if (ref_exit) en_cnt = 0;
      else if (bus.count_en && (en_cnt < T_REFI - 1)) en_cnt++;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
